// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, ALU operation codes and control/pipeline types for the ID/EX slice
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_SLTI  = 6'h0A;

  typedef enum logic [3:0] {
    ALUOP_ADD         = 4'd0,
    ALUOP_SUB         = 4'd1,
    ALUOP_AND         = 4'd2,
    ALUOP_OR          = 4'd3,
    ALUOP_SLT         = 4'd4,
    ALUOP_RTYPE_FUNCT = 4'd5
  } aluop_e;

  typedef struct packed {
    aluop_e aluop;
    logic   alusrc;
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   memtoreg;
    logic   branch;
    logic   illegal;
    logic   dest_rt;
    logic   zero_ext;
    logic   uses_rt;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] pc4;
    logic [3:0]  aluop;
    logic        alusrc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        branch;
    logic        illegal;
  } ex_reg_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational opcode to control-bundle decoder
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] i_opcode,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl       = ctrl_t'('0);
    o_ctrl.aluop = ALUOP_ADD;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.aluop    = ALUOP_RTYPE_FUNCT;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.uses_rt  = 1'b1;
      end
      OP_LW: begin
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.memread  = 1'b1;
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.dest_rt  = 1'b1;
      end
      OP_SW: begin
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.memwrite = 1'b1;
        o_ctrl.uses_rt  = 1'b1;
      end
      OP_BEQ: begin
        o_ctrl.aluop   = ALUOP_SUB;
        o_ctrl.branch  = 1'b1;
        o_ctrl.uses_rt = 1'b1;
      end
      OP_ADDI, OP_SLTI: begin
        o_ctrl.aluop    = (i_opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.dest_rt  = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        o_ctrl.aluop    = (i_opcode == OP_ANDI) ? ALUOP_AND : ALUOP_OR;
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.dest_rt  = 1'b1;
        o_ctrl.zero_ext = 1'b1;
      end
      default: o_ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode stage with writeback bypass, load-use stall and ID/EX register
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int BYPASS_EN = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc4,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic        flush,
  output logic        stall_out,
  output logic        ex_valid,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_dest,
  output logic [31:0] ex_pc4,
  output logic [3:0]  ex_aluop,
  output logic        ex_alusrc,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_memtoreg,
  output logic        ex_branch,
  output logic        ex_illegal
);

  ctrl_t       w_ctrl;
  ex_reg_t     w_next;
  ex_reg_t     r_ex;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_dest;
  logic        w_load_use;
  logic        w_bubble;

  // $0 reads as zero even if the writeback bus targets it
  function automatic logic [31:0] sel_operand(input logic [4:0] addr, input logic [31:0] rdata);
    if (addr == 5'd0) return 32'd0;
    if ((BYPASS_EN != 0) && wb_we && (wb_waddr == addr)) return wb_wdata;
    return rdata;
  endfunction

  mips_ctrl_decode u_decode (
    .i_opcode (id_instr[31:26]),
    .o_ctrl   (w_ctrl)
  );

  assign w_rs      = id_instr[25:21];
  assign w_rt      = id_instr[20:16];
  assign rf_raddr1 = w_rs;
  assign rf_raddr2 = w_rt;
  assign w_dest    = w_ctrl.regwrite ? (w_ctrl.dest_rt ? w_rt : id_instr[15:11]) : 5'd0;

  assign w_load_use = r_ex.valid && r_ex.memread && (r_ex.dest != 5'd0) &&
                      ((r_ex.dest == w_rs) || ((r_ex.dest == w_rt) && w_ctrl.uses_rt));
  assign stall_out  = id_valid && !flush && w_load_use;
  assign w_bubble   = !id_valid || flush || w_load_use;

  always_comb begin
    w_next          = '0;
    w_next.valid    = 1'b1;
    w_next.a        = sel_operand(w_rs, rf_rdata1);
    w_next.b        = sel_operand(w_rt, rf_rdata2);
    w_next.imm      = w_ctrl.zero_ext ? {16'd0, id_instr[15:0]} : {{16{id_instr[15]}}, id_instr[15:0]};
    w_next.rs       = w_rs;
    w_next.rt       = w_rt;
    w_next.dest     = w_dest;
    w_next.pc4      = id_pc4;
    w_next.aluop    = w_ctrl.aluop;
    w_next.alusrc   = w_ctrl.alusrc;
    w_next.regwrite = w_ctrl.regwrite && (w_dest != 5'd0);
    w_next.memread  = w_ctrl.memread;
    w_next.memwrite = w_ctrl.memwrite;
    w_next.memtoreg = w_ctrl.memtoreg;
    w_next.branch   = w_ctrl.branch;
    w_next.illegal  = w_ctrl.illegal;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ex <= '0;
    end else if (w_bubble) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_next;
    end
  end

  assign ex_valid    = r_ex.valid;
  assign ex_a        = r_ex.a;
  assign ex_b        = r_ex.b;
  assign ex_imm      = r_ex.imm;
  assign ex_rs       = r_ex.rs;
  assign ex_rt       = r_ex.rt;
  assign ex_dest     = r_ex.dest;
  assign ex_pc4      = r_ex.pc4;
  assign ex_aluop    = r_ex.aluop;
  assign ex_alusrc   = r_ex.alusrc;
  assign ex_regwrite = r_ex.regwrite;
  assign ex_memread  = r_ex.memread;
  assign ex_memwrite = r_ex.memwrite;
  assign ex_memtoreg = r_ex.memtoreg;
  assign ex_branch   = r_ex.branch;
  assign ex_illegal  = r_ex.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage with bypass on and off
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        flush;

  logic [4:0]  rf_raddr1, rf_raddr2, nb_raddr1, nb_raddr2;
  logic        stall_out, nb_stall;
  logic        ex_valid, nb_valid;
  logic [31:0] ex_a, ex_b, ex_imm, ex_pc4, nb_a, nb_b, nb_imm, nb_pc4;
  logic [4:0]  ex_rs, ex_rt, ex_dest, nb_rs, nb_rt, nb_dest;
  logic [3:0]  ex_aluop, nb_aluop;
  logic        ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, ex_illegal;
  logic        nb_alusrc, nb_regwrite, nb_memread, nb_memwrite, nb_memtoreg, nb_branch, nb_illegal;

  always #5 clock = ~clock;

  id_ex_stage u_dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .flush(flush), .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dest(ex_dest), .ex_pc4(ex_pc4), .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  id_ex_stage #(.BYPASS_EN(0)) u_dut_nb (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
    .rf_raddr1(nb_raddr1), .rf_raddr2(nb_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .flush(flush), .stall_out(nb_stall),
    .ex_valid(nb_valid), .ex_a(nb_a), .ex_b(nb_b), .ex_imm(nb_imm), .ex_rs(nb_rs), .ex_rt(nb_rt),
    .ex_dest(nb_dest), .ex_pc4(nb_pc4), .ex_aluop(nb_aluop), .ex_alusrc(nb_alusrc),
    .ex_regwrite(nb_regwrite), .ex_memread(nb_memread), .ex_memwrite(nb_memwrite),
    .ex_memtoreg(nb_memtoreg), .ex_branch(nb_branch), .ex_illegal(nb_illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] pc4;
    logic [3:0]  aluop;
    logic [6:0]  ctl;
  } exp_t;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        fl;
    logic        st;
    exp_t        e;
    logic [31:0] nba;
  } vec_t;

  // ctl = {alusrc, regwrite, memread, memwrite, memtoreg, branch, illegal}
  localparam logic [6:0] C_R    = 7'b0100000;
  localparam logic [6:0] C_LW   = 7'b1110100;
  localparam logic [6:0] C_LW0  = 7'b1010100;
  localparam logic [6:0] C_SW   = 7'b1001000;
  localparam logic [6:0] C_BEQ  = 7'b0000010;
  localparam logic [6:0] C_IMM  = 7'b1100000;
  localparam logic [6:0] C_ILL  = 7'b0000001;
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_SLT = 4'd4, A_R = 4'd5;

  localparam logic [31:0] I_ADD312  = 32'h00221820;
  localparam logic [31:0] I_LW41    = 32'h8C240000;
  localparam logic [31:0] I_ADD542  = 32'h00822820;
  localparam logic [31:0] I_SW21    = 32'hAC220008;

  exp_t        q_exp[$];
  logic [31:0] q_nba[$];
  string       q_name[$];
  vec_t        tbl[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] pc = 32'h0000_1000;

  function automatic exp_t ex(input logic [31:0] a, b, imm, input logic [4:0] rs, rt, dest,
                              input logic [3:0] op, input logic [6:0] c);
    exp_t r;
    r = '0;
    r.valid = 1'b1; r.a = a; r.b = b; r.imm = imm; r.rs = rs; r.rt = rt; r.dest = dest;
    r.aluop = op; r.ctl = c;
    return r;
  endfunction

  function automatic vec_t mk(input string n, input logic v, input logic [31:0] instr, rd1, rd2,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic fl, input logic st, input exp_t e, input logic [31:0] nba);
    vec_t r;
    r.name = n; r.v = v; r.instr = instr; r.rd1 = rd1; r.rd2 = rd2; r.we = we; r.wa = wa;
    r.wd = wd; r.fl = fl; r.st = st; r.e = e; r.nba = nba;
    return r;
  endfunction

  function automatic exp_t act_now();
    return {ex_valid, ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_dest, ex_pc4, ex_aluop,
            ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, ex_illegal};
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, expv);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.v; id_instr = v.instr; id_pc4 = pc; rf_rdata1 = v.rd1; rf_rdata2 = v.rd2;
    wb_we = v.we; wb_waddr = v.wa; wb_wdata = v.wd; flush = v.fl;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clock);
    drive(v);
    #1;
    chk({v.name, "_stall"}, 160'(stall_out), 160'(v.st));
    if (v.e.valid) chk({v.name, "_raddr"}, 160'({rf_raddr1, rf_raddr2}), 160'({v.e.rs, v.e.rt}));
    e = v.e;
    if (e.valid) e.pc4 = pc;
    q_exp.push_back(e);
    q_nba.push_back(v.nba);
    q_name.push_back(v.name);
    @(posedge clock);
    #1;
    got = act_now();
    chk(q_name[0], 160'(got), 160'(q_exp.pop_front()));
    chk({q_name.pop_front(), "_nobypass_a"}, 160'(nb_a), 160'(q_nba.pop_front()));
    pc = pc + 32'd4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    drive(mk("idle", 1'b1, I_LW41, 32'h5, 32'h6, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, '0, 32'd0));
    #2;
    chk("reset_ex", 160'(act_now()), 160'd0);
    chk("reset_stall", 160'(stall_out), 160'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    tbl.push_back(mk("add", 1, I_ADD312, 8, 20, 0, 0, 0, 0, 0, ex(8, 20, 32'h1820, 1, 2, 3, A_R, C_R), 8));
    tbl.push_back(mk("add_byp", 1, I_ADD312, 8, 20, 1, 1, 32'h55, 0, 0, ex(32'h55, 20, 32'h1820, 1, 2, 3, A_R, C_R), 8));
    tbl.push_back(mk("add_byp_rt", 1, I_ADD312, 8, 20, 1, 2, 32'hABCD, 0, 0, ex(8, 32'hABCD, 32'h1820, 1, 2, 3, A_R, C_R), 8));
    tbl.push_back(mk("andi", 1, 32'h3026FFFF, 3, 7, 0, 0, 0, 0, 0, ex(3, 7, 32'h0000FFFF, 1, 6, 6, A_AND, C_IMM), 3));
    tbl.push_back(mk("addi", 1, 32'h2027FFFF, 3, 7, 0, 0, 0, 0, 0, ex(3, 7, 32'hFFFFFFFF, 1, 7, 7, A_ADD, C_IMM), 3));
    tbl.push_back(mk("illegal", 1, 32'hFC221820, 1, 2, 0, 0, 0, 0, 0, ex(1, 2, 32'h1820, 1, 2, 0, A_ADD, C_ILL), 1));
    tbl.push_back(mk("sw", 1, I_SW21, 32'h1000, 32'h77, 0, 0, 0, 0, 0, ex(32'h1000, 32'h77, 8, 1, 2, 0, A_ADD, C_SW), 32'h1000));
    tbl.push_back(mk("beq", 1, 32'h1022FFFF, 5, 5, 0, 0, 0, 0, 0, ex(5, 5, 32'hFFFFFFFF, 1, 2, 0, A_SUB, C_BEQ), 5));
    tbl.push_back(mk("ori", 1, 32'h34288001, 32'hF0, 0, 0, 0, 0, 0, 0, ex(32'hF0, 0, 32'h8001, 1, 8, 8, A_OR, C_IMM), 32'hF0));
    tbl.push_back(mk("slti", 1, 32'h28298000, 32'hA, 32'hB, 0, 0, 0, 0, 0, ex(32'hA, 32'hB, 32'hFFFF8000, 1, 9, 9, A_SLT, C_IMM), 32'hA));
    tbl.push_back(mk("add_rd0", 1, 32'h00220020, 4, 5, 0, 0, 0, 0, 0, ex(4, 5, 32'h20, 1, 2, 0, A_R, C_NONE), 4));
    tbl.push_back(mk("add_rs0", 1, 32'h00021820, 99, 6, 1, 0, 32'h33, 0, 0, ex(0, 6, 32'h1820, 0, 2, 3, A_R, C_R), 0));
    tbl.push_back(mk("novalid", 0, I_ADD312, 8, 20, 0, 0, 0, 0, 0, '0, 0));
    tbl.push_back(mk("flush", 1, I_ADD312, 8, 20, 0, 0, 0, 1, 0, '0, 0));
    tbl.push_back(mk("lw", 1, I_LW41, 32'h200, 9, 0, 0, 0, 0, 0, ex(32'h200, 9, 0, 1, 4, 4, A_ADD, C_LW), 32'h200));
    tbl.push_back(mk("add_nodep", 1, I_ADD312, 8, 20, 0, 0, 0, 0, 0, ex(8, 20, 32'h1820, 1, 2, 3, A_R, C_R), 8));
    tbl.push_back(mk("lw_b", 1, I_LW41, 32'h200, 9, 0, 0, 0, 0, 0, ex(32'h200, 9, 0, 1, 4, 4, A_ADD, C_LW), 32'h200));
    tbl.push_back(mk("addi_rt4", 1, 32'h20240001, 2, 3, 0, 0, 0, 0, 0, ex(2, 3, 1, 1, 4, 4, A_ADD, C_IMM), 2));
    foreach (tbl[i]) apply(tbl[i]);

    // load-use on rs: one stall cycle, one bubble, then the add is taken
    apply(mk("lu_lw", 1, I_LW41, 32'h200, 9, 0, 0, 0, 0, 0, ex(32'h200, 9, 0, 1, 4, 4, A_ADD, C_LW), 32'h200));
    apply(mk("lu_stall", 1, I_ADD542, 32'h11, 32'h22, 0, 0, 0, 0, 1, '0, 0));
    apply(mk("lu_add", 1, I_ADD542, 32'h11, 32'h22, 0, 0, 0, 0, 0, ex(32'h11, 32'h22, 32'h2820, 4, 2, 5, A_R, C_R), 32'h11));
    // load-use on rt through sw
    apply(mk("lu_lw2", 1, 32'h8C220000, 32'h300, 1, 0, 0, 0, 0, 0, ex(32'h300, 1, 0, 1, 2, 2, A_ADD, C_LW), 32'h300));
    apply(mk("lu_sw_stall", 1, I_SW21, 32'h1000, 32'h77, 0, 0, 0, 0, 1, '0, 0));
    apply(mk("lu_sw", 1, I_SW21, 32'h1000, 32'h77, 0, 0, 0, 0, 0, ex(32'h1000, 32'h77, 8, 1, 2, 0, A_ADD, C_SW), 32'h1000));
    // flush beats load-use
    apply(mk("fl_lw", 1, I_LW41, 32'h200, 9, 0, 0, 0, 0, 0, ex(32'h200, 9, 0, 1, 4, 4, A_ADD, C_LW), 32'h200));
    apply(mk("fl_lu", 1, I_ADD542, 32'h11, 32'h22, 0, 0, 0, 1, 0, '0, 0));
    apply(mk("fl_after", 1, I_ADD542, 32'h11, 32'h22, 0, 0, 0, 0, 0, ex(32'h11, 32'h22, 32'h2820, 4, 2, 5, A_R, C_R), 32'h11));
    // hazard with no valid decode does not stall
    apply(mk("nv_lw", 1, I_LW41, 32'h200, 9, 0, 0, 0, 0, 0, ex(32'h200, 9, 0, 1, 4, 4, A_ADD, C_LW), 32'h200));
    apply(mk("nv_lu", 0, I_ADD542, 32'h11, 32'h22, 0, 0, 0, 0, 0, '0, 0));
    // load to $0 never creates a hazard
    apply(mk("lw0", 1, 32'h8C200000, 32'h200, 9, 0, 0, 0, 0, 0, ex(32'h200, 0, 0, 1, 0, 0, A_ADD, C_LW0), 32'h200));
    apply(mk("lw0_use", 1, 32'h00022820, 32'h11, 32'h22, 0, 0, 0, 0, 0, ex(0, 32'h22, 32'h2820, 0, 2, 5, A_R, C_R), 0));

    // reset in the middle of a stall
    apply(mk("rs_lw", 1, I_LW41, 32'h200, 9, 0, 0, 0, 0, 0, ex(32'h200, 9, 0, 1, 4, 4, A_ADD, C_LW), 32'h200));
    @(negedge clock);
    drive(mk("rs_lu", 1, I_ADD542, 32'h11, 32'h22, 0, 0, 0, 0, 1, '0, 0));
    #1;
    chk("rs_pre_stall", 160'(stall_out), 160'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("rs_async_ex", 160'(act_now()), 160'd0);
    chk("rs_async_stall", 160'(stall_out), 160'd0);
    chk("rs_async_nb_valid", 160'(nb_valid), 160'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    apply(mk("rs_after", 1, I_ADD542, 32'h11, 32'h22, 0, 0, 0, 0, 0, ex(32'h11, 32'h22, 32'h2820, 4, 2, 5, A_R, C_R), 32'h11));

    chk("queue_empty", 160'(q_exp.size()), 160'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
